// File: rtl/vram_glyph_writer_if.sv
// Bus bundle for vram_glyph_writer: character handshake, glyph ROM port and
// framebuffer write port. The slave modport is the writer's view; the master
// modport is the surrounding system (code source, ROM, framebuffer).
// Optional inverse-video input exists only when VRAM_GLYPH_INVERSE_EN is defined.
interface vram_glyph_writer_if;
  logic        char_valid;
  logic [7:0]  char_code;
  logic        char_ready;
`ifdef VRAM_GLYPH_INVERSE_EN
  logic        inv;
`endif
  logic [12:0] rom_addr;
  logic [15:0] rom_data;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_be;

`ifdef VRAM_GLYPH_INVERSE_EN
  modport slave (input char_valid, char_code, inv, rom_data,
                 output char_ready, rom_addr, wr_en, wr_addr, wr_data, wr_be);
  modport master (output char_valid, char_code, inv, rom_data,
                  input char_ready, rom_addr, wr_en, wr_addr, wr_data, wr_be);
`else
  modport slave (input char_valid, char_code, rom_data,
                 output char_ready, rom_addr, wr_en, wr_addr, wr_data, wr_be);
  modport master (output char_valid, char_code, rom_data,
                  input char_ready, rom_addr, wr_en, wr_addr, wr_data, wr_be);
`endif
endinterface

// File: rtl/vram_glyph_writer.sv
// vram_glyph_writer: takes character codes, fetches 16x32 glyph rows from an
// external ROM and writes them into a 1bpp 32-bit-word framebuffer at the text
// cursor. Handles clear-screen (0x0C), newline (0x0A) and carriage return (0x0D).
// Optional inverse video is enabled by defining VRAM_GLYPH_INVERSE_EN.
module vram_glyph_writer #(
  parameter int COLS           = 40,
  parameter int ROWS           = 15,
  parameter int GLYPH_H        = 32,
  parameter int WORDS_PER_LINE = 20,
  parameter int FB_WORDS       = 9600
) (
  input  logic                    CLK,
  input  logic                    reset,
  vram_glyph_writer_if.slave      bus,
  output logic [5:0]              cur_col,
  output logic [3:0]              cur_row
);

  typedef enum logic [1:0] {IDLE, GLYPH, CLEAR} state_t;

  state_t      state, state_d;
  logic [5:0]  cnt, cnt_d;          // glyph lines already written (0..GLYPH_H)
  logic [13:0] ptr, ptr_d;          // next framebuffer address to write
  logic [7:0]  code, code_d;        // latched glyph code
  logic [5:0]  col_d;
  logic [3:0]  row_d;
  logic [12:0] rom_addr_q, rom_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [13:0] wr_addr_q, wr_addr_d;
  logic [1:0]  wr_be_q, wr_be_d;
  logic [13:0] row_base;
  logic [15:0] half;
  logic        accept;
`ifdef VRAM_GLYPH_INVERSE_EN
  logic        inv_q, inv_d;
`endif

  assign accept   = bus.char_valid && (state == IDLE);
  // Start of the current text row in the framebuffer, computed at full width.
  assign row_base = 14'(cur_row) * 14'(GLYPH_H * WORDS_PER_LINE);

  assign bus.char_ready = (state == IDLE);
  assign bus.rom_addr   = rom_addr_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_be      = wr_be_q;

  // ROM data arrives the cycle the write is presented, so data is steered
  // combinationally into the enabled half; wr_be=0 (idle/reset) and
  // wr_be=11 (clear) both give zero data.
  always_comb begin
`ifdef VRAM_GLYPH_INVERSE_EN
    half = inv_q ? ~bus.rom_data : bus.rom_data;
`else
    half = bus.rom_data;
`endif
    case (wr_be_q)
      2'b10:   bus.wr_data = {half, 16'h0};
      2'b01:   bus.wr_data = {16'h0, half};
      default: bus.wr_data = 32'h0;
    endcase
  end

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ptr_d      = ptr;
    code_d     = code;
    col_d      = cur_col;
    row_d      = cur_row;
    rom_addr_d = rom_addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_be_d    = 2'b00;
`ifdef VRAM_GLYPH_INVERSE_EN
    inv_d      = inv_q;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.char_code)
            8'h0C: begin
              state_d = CLEAR;
              ptr_d   = 14'd0;
            end
            8'h0A: begin
              col_d = 6'd0;
              row_d = (cur_row == 4'(ROWS - 1)) ? 4'd0 : cur_row + 4'd1;
            end
            8'h0D: col_d = 6'd0;
            default: begin
              state_d    = GLYPH;
              cnt_d      = 6'd0;
              code_d     = bus.char_code;
              rom_addr_d = {bus.char_code, 5'd0};
              ptr_d      = row_base + {9'd0, cur_col[5:1]};
`ifdef VRAM_GLYPH_INVERSE_EN
              inv_d      = bus.inv;
`endif
            end
          endcase
        end
      end
      GLYPH: begin
        if (cnt == 6'(GLYPH_H)) begin
          // All lines written: advance cursor, wrapping to the top with no scroll.
          state_d = IDLE;
          if (cur_col == 6'(COLS - 1)) begin
            col_d = 6'd0;
            row_d = (cur_row == 4'(ROWS - 1)) ? 4'd0 : cur_row + 4'd1;
          end else begin
            col_d = cur_col + 6'd1;
          end
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr;
          wr_be_d   = cur_col[0] ? 2'b01 : 2'b10;
          ptr_d     = ptr + 14'(WORDS_PER_LINE);
          cnt_d     = cnt + 6'd1;
          if (cnt != 6'(GLYPH_H - 1))
            rom_addr_d = {code, cnt_d[4:0]};
        end
      end
      CLEAR: begin
        if (ptr == 14'(FB_WORDS)) begin
          state_d = IDLE;
          col_d   = 6'd0;
          row_d   = 4'd0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr;
          wr_be_d   = 2'b11;
          ptr_d     = ptr + 14'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any operation immediately.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      ptr        <= 14'd0;
      code       <= 8'd0;
      cur_col    <= 6'd0;
      cur_row    <= 4'd0;
      rom_addr_q <= 13'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 14'd0;
      wr_be_q    <= 2'b00;
`ifdef VRAM_GLYPH_INVERSE_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ptr        <= ptr_d;
      code       <= code_d;
      cur_col    <= col_d;
      cur_row    <= row_d;
      rom_addr_q <= rom_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_be_q    <= wr_be_d;
`ifdef VRAM_GLYPH_INVERSE_EN
      inv_q      <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_vram_glyph_writer.sv
// Directed self-checking bench for vram_glyph_writer. A synchronous glyph ROM
// model returns 16'h8000 >> (line % 16) one cycle after the address.
module tb_vram_glyph_writer;
  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] cur_col;
  logic [3:0] cur_row;
  int checks = 0;
  int failures = 0;
  int m_col = 0;
  int m_row = 0;

  vram_glyph_writer_if bus ();

  vram_glyph_writer dut (
    .CLK(CLK), .reset(reset), .bus(bus), .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 CLK = ~CLK;

  // Glyph ROM model.
  always @(posedge CLK) bus.rom_data <= 16'h8000 >> bus.rom_addr[3:0];

  task automatic test_reset();
    bus.char_valid = 1'b0;
    bus.char_code  = 8'h00;
`ifdef VRAM_GLYPH_INVERSE_EN
    bus.inv = 1'b0;
`endif
    reset = 1'b1;
    #3;
    checks++;
    if ({bus.char_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be, bus.rom_addr, cur_col, cur_row}
        !== {1'b1, 1'b0, 14'd0, 32'd0, 2'b00, 13'd0, 6'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_values rdy=%b en=%b addr=%0d data=%h be=%b rom=%h col=%0d row=%0d exp rdy=1 rest 0",
               bus.char_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be, bus.rom_addr, cur_col, cur_row);
    end
    @(negedge CLK);
    reset = 1'b0;
    m_col = 0;
    m_row = 0;
  endtask

  // Send one printable code and check the full 33-cycle write sequence.
  // hold=1 keeps char_valid high with code c+1 during the busy period.
  task automatic glyph(input logic [7:0] c, input bit hold, input bit inv_v);
    logic [13:0] exp_addr;
    logic [15:0] rowv;
    logic [31:0] exp_d;
    logic [1:0]  exp_be;
    exp_be = (m_col % 2 == 1) ? 2'b01 : 2'b10;
    @(negedge CLK);
    bus.char_valid = 1'b1;
    bus.char_code  = c;
`ifdef VRAM_GLYPH_INVERSE_EN
    bus.inv = inv_v;
`endif
    @(posedge CLK); #1;
    if (hold) bus.char_code = c + 8'd1;
    else bus.char_valid = 1'b0;
    checks++;
    if ({bus.rom_addr, bus.char_ready} !== {c, 5'd0, 1'b0}) begin
      failures++;
      $display("FAIL glyph_accept code=%h rom=%h rdy=%b exp rom=%h rdy=0", c, bus.rom_addr, bus.char_ready, {c, 5'd0});
    end
    for (int k = 1; k <= 33; k++) begin
      @(posedge CLK); #1;
      if (k <= 32) begin
        exp_addr = 14'(m_row * 640 + (k - 1) * 20 + m_col / 2);
        rowv = 16'h8000 >> ((k - 1) % 16);
`ifdef VRAM_GLYPH_INVERSE_EN
        if (inv_v) rowv = ~rowv;
`else
        if (inv_v) rowv = rowv;
`endif
        exp_d = (exp_be == 2'b10) ? {rowv, 16'h0} : {16'h0, rowv};
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_be, bus.wr_data, bus.char_ready, cur_col, cur_row}
            !== {1'b1, exp_addr, exp_be, exp_d, 1'b0, 6'(m_col), 4'(m_row)}) begin
          failures++;
          $display("FAIL glyph_write code=%h cyc=%0d en=%b addr=%0d be=%b data=%h rdy=%b col=%0d row=%0d exp en=1 addr=%0d be=%b data=%h rdy=0 col=%0d row=%0d",
                   c, k, bus.wr_en, bus.wr_addr, bus.wr_be, bus.wr_data, bus.char_ready, cur_col, cur_row,
                   exp_addr, exp_be, exp_d, m_col, m_row);
        end
        if (k <= 31) begin
          checks++;
          if (bus.rom_addr !== {c, 5'(k)}) begin
            failures++;
            $display("FAIL glyph_rom_addr code=%h cyc=%0d got=%h exp=%h", c, k, bus.rom_addr, {c, 5'(k)});
          end
        end
      end else begin
        if (m_col == 39) begin
          m_col = 0;
          m_row = (m_row == 14) ? 0 : m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
        checks++;
        if ({bus.wr_en, bus.char_ready, cur_col, cur_row} !== {1'b0, 1'b1, 6'(m_col), 4'(m_row)}) begin
          failures++;
          $display("FAIL glyph_done code=%h en=%b rdy=%b col=%0d row=%0d exp en=0 rdy=1 col=%0d row=%0d",
                   c, bus.wr_en, bus.char_ready, cur_col, cur_row, m_col, m_row);
        end
      end
    end
  endtask

  // Newline / carriage return: no writes, ready never drops.
  task automatic ctrl(input logic [7:0] c);
    @(negedge CLK);
    bus.char_valid = 1'b1;
    bus.char_code  = c;
    @(posedge CLK); #1;
    bus.char_valid = 1'b0;
    m_col = 0;
    if (c == 8'h0A) m_row = (m_row == 14) ? 0 : m_row + 1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.wr_en, bus.char_ready, cur_col, cur_row} !== {1'b0, 1'b1, 6'(m_col), 4'(m_row)}) begin
        failures++;
        $display("FAIL ctrl code=%h cyc=%0d en=%b rdy=%b col=%0d row=%0d exp en=0 rdy=1 col=%0d row=%0d",
                 c, k, bus.wr_en, bus.char_ready, cur_col, cur_row, m_col, m_row);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_glyph_col0();
    glyph(8'h41, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    glyph(8'h42, 1'b1, 1'b0);
    glyph(8'h43, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    ctrl(8'h0D);
    for (int i = 0; i < 14; i++) ctrl(8'h0A);
    for (int i = 0; i < 39; i++) glyph(8'h50, 1'b0, 1'b0);
    // Cursor now (row 14, col 39): last write lands at 9599, cursor wraps to (0,0).
    glyph(8'h51, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    int sr;
    int sc;
    ctrl(8'h0A);
    ctrl(8'h0A);
    glyph(8'h60, 1'b0, 1'b0);
    glyph(8'h61, 1'b0, 1'b0);
    sr = m_row;
    sc = m_col;
    @(negedge CLK);
    bus.char_valid = 1'b1;
    bus.char_code  = 8'h0C;
    @(posedge CLK); #1;
    bus.char_valid = 1'b0;
    checks++;
    if ({bus.wr_en, bus.char_ready} !== 2'b00) begin
      failures++;
      $display("FAIL clear_accept en=%b rdy=%b exp en=0 rdy=0", bus.wr_en, bus.char_ready);
    end
    for (int k = 1; k <= 9601; k++) begin
      @(posedge CLK); #1;
      if (k <= 9600) begin
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_be, bus.wr_data, bus.char_ready, cur_col, cur_row}
            !== {1'b1, 14'(k - 1), 2'b11, 32'd0, 1'b0, 6'(sc), 4'(sr)}) begin
          failures++;
          $display("FAIL clear_write cyc=%0d en=%b addr=%0d be=%b data=%h rdy=%b col=%0d row=%0d exp en=1 addr=%0d be=11 data=0 rdy=0 col=%0d row=%0d",
                   k, bus.wr_en, bus.wr_addr, bus.wr_be, bus.wr_data, bus.char_ready, cur_col, cur_row, k - 1, sc, sr);
        end
      end else begin
        checks++;
        if ({bus.wr_en, bus.char_ready, cur_col, cur_row} !== {1'b0, 1'b1, 6'd0, 4'd0}) begin
          failures++;
          $display("FAIL clear_done en=%b rdy=%b col=%0d row=%0d exp en=0 rdy=1 col=0 row=0",
                   bus.wr_en, bus.char_ready, cur_col, cur_row);
        end
      end
    end
    m_col = 0;
    m_row = 0;
  endtask

  task automatic test_newline();
    for (int i = 0; i < 14; i++) ctrl(8'h0A);
    for (int i = 0; i < 5; i++) glyph(8'h70, 1'b0, 1'b0);
    ctrl(8'h0A);                 // row 14 col 5 -> (0,0)
    glyph(8'h71, 1'b0, 1'b0);    // col 1
    ctrl(8'h0A);                 // row 1 col 0
    glyph(8'h72, 1'b0, 1'b0);    // row 1 col 1
    ctrl(8'h0D);                 // row 1 col 0
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    bus.char_valid = 1'b1;
    bus.char_code  = 8'h44;
    @(posedge CLK); #1;
    bus.char_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.char_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be, bus.rom_addr, cur_col, cur_row}
        !== {1'b1, 1'b0, 14'd0, 32'd0, 2'b00, 13'd0, 6'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_mid rdy=%b en=%b addr=%0d data=%h be=%b rom=%h col=%0d row=%0d exp rdy=1 rest 0",
               bus.char_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be, bus.rom_addr, cur_col, cur_row);
    end
    @(negedge CLK);
    reset = 1'b0;
    m_col = 0;
    m_row = 0;
    glyph(8'h45, 1'b0, 1'b0);
  endtask

  task automatic test_inverse();
`ifdef VRAM_GLYPH_INVERSE_EN
    glyph(8'h46, 1'b0, 1'b1);
    glyph(8'h47, 1'b0, 1'b1);
    bus.inv = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_glyph_col0();
    test_back_to_back();
    test_wrap();
    test_clear();
    test_newline();
    test_reset_mid();
    test_inverse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
